// File: rtl/pwm_out.sv
// pwm_out: ESC pulse generator with an arming sequence and frame-aligned,
// clamped throttle updates from a sign-magnitude PID correction.
module pwm_out #(
    parameter int PERIOD_CYCLES = 20000,
    parameter int MIN_PULSE     = 1000,
    parameter int MAX_PULSE     = 2000,
    parameter int SHIFT         = 5,
    parameter int ARM_PERIODS   = 50
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        pid_valid,
    input  logic [31:0] pid_out,
    input  logic [15:0] base_throttle,
    output logic        pwm,
    output logic [15:0] active_width,
    output logic        armed,
    output logic        sat,
    output logic        frame_start
);
    localparam int CW = $clog2(PERIOD_CYCLES);
    localparam int AW = $clog2(ARM_PERIODS + 1);
    localparam logic signed [32:0] SMIN = 33'(MIN_PULSE);
    localparam logic signed [32:0] SMAX = 33'(MAX_PULSE);
    typedef enum logic [1:0] {DISARMED, ARMING, RUN} state_t;
    state_t state, state_n;
    logic [CW-1:0] cnt;
    logic [AW-1:0] arm_cnt;
    logic [15:0] pending, clamped;
    logic pending_valid, wrap, lo, hi;
    logic [30:0] corr;
    logic signed [32:0] sum;
    assign wrap = cnt == CW'(PERIOD_CYCLES - 1);
    // 33-bit signed math so a full-scale correction can never wrap past the clamp
    always_comb begin
        corr = pid_out[30:0] >> SHIFT;
        sum = pid_out[31] ? $signed({17'd0, base_throttle}) - $signed({2'b00, corr})
                          : $signed({17'd0, base_throttle}) + $signed({2'b00, corr});
        lo = sum < SMIN;
        hi = sum > SMAX;
        clamped = lo ? 16'(MIN_PULSE) : hi ? 16'(MAX_PULSE) : sum[15:0];
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= DISARMED;
        else
            state <= state_n;
    end
    always_comb begin
        state_n = !en ? DISARMED
                : state == DISARMED ? ARMING
                : (state == ARMING && wrap && arm_cnt == AW'(ARM_PERIODS - 1)) ? RUN
                : state;
    end
    always_comb begin
        pwm = state != DISARMED && 32'(cnt) < 32'(active_width);
        armed = state == RUN;
        frame_start = state != DISARMED && cnt == '0;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            arm_cnt <= '0;
            pending <= '0;
            pending_valid <= 1'b0;
            active_width <= 16'(MIN_PULSE);
            sat <= 1'b0;
        end else if (!en || state == DISARMED) begin
            cnt <= '0;
            arm_cnt <= '0;
            pending_valid <= 1'b0;
            active_width <= 16'(MIN_PULSE);
        end else begin
            cnt <= wrap ? '0 : cnt + CW'(1);
            if (state == ARMING) begin
                active_width <= 16'(MIN_PULSE);
                if (wrap)
                    arm_cnt <= arm_cnt + AW'(1);
            end else begin
                if (wrap && pending_valid)
                    active_width <= pending;
                // a sample landing on the wrap edge survives as pending for the next frame
                pending_valid <= pid_valid | (pending_valid & ~wrap);
                if (pid_valid) begin
                    pending <= clamped;
                    sat <= lo | hi;
                end
            end
        end
    end
endmodule
